sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 114 +++++++++++
 tb/tb_sync_debounce.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// Synchronizes an asynchronous level input and accepts a change only after it
// has held for DB_CYCLES qualifying en-samples; reports edges and qualification.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned     CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        STABLE,
        CHANGING
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q;
    state_t                 state_next;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_next;
    logic                   dout_q;
    logic                   dout_next;
    logic                   rise_q;
    logic                   rise_next;
    logic                   fall_q;
    logic                   fall_next;
    logic                   busy_q;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            dout_q  <= dout_next;
            rise_q  <= rise_next;
            fall_q  <= fall_next;
            busy_q  <= (state_next == CHANGING);
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            STABLE: begin
                if (s != dout_q) begin
                    state_next = CHANGING;
                end
            end
            CHANGING: begin
                if (s == dout_q) begin
                    state_next = STABLE;
                end else if (en && (cnt_q == CNT_LAST)) begin
                    state_next = STABLE;
                end
            end
            default: state_next = STABLE;
        endcase
    end

    // Next values of the registered outputs; any agreement clears cnt, so no
    // partial credit survives a glitch.
    always_comb begin
        cnt_next  = '0;
        dout_next = dout_q;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if ((state_q == CHANGING) && (s != dout_q)) begin
            if (!en) begin
                cnt_next = cnt_q;
            end else if (cnt_q == CNT_LAST) begin
                dout_next = s;
                rise_next = s;
                fall_next = ~s;
            end else begin
                cnt_next = cnt_q + CW'(1);
            end
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus queues per-edge expected
// {dout,rise,fall,busy}; a monitor compares after each rising edge.
module tb_sync_debounce;

    logic clk;
    logic rstn;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int unsigned total;
    int unsigned passed;

    logic [3:0] exp_q[$];
    int         id_q[$];

    localparam int ID_PWR   = 0;
    localparam int ID_GLT   = 1;
    localparam int ID_ENG   = 2;
    localparam int ID_FALL  = 3;
    localparam int ID_RISE  = 4;
    localparam int ID_QUIET = 5;
    localparam int ID_MID   = 6;

    sync_debounce #(
        .SYNC_STAGES(2),
        .DB_CYCLES  (16),
        .RESET_VAL  (1'b0)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .din (din),
        .en  (en),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string nm(input int id);
        case (id)
            ID_PWR:   return "powerup";
            ID_GLT:   return "glitch";
            ID_ENG:   return "en_gating";
            ID_FALL:  return "clean_fall";
            ID_RISE:  return "clean_rise";
            ID_QUIET: return "post_reset_quiet";
            ID_MID:   return "reset_midcount";
            default:  return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at %0t: {dout,rise,fall,busy} got %b expected %b",
                     name, $time, act, exp);
        end
    endtask

    // One input cycle: drive at the falling edge, queue what the next rising edge must produce.
    task automatic cyc(input logic r, input logic d, input logic e, input logic [3:0] exp, input int id);
        @(negedge clk);
        rstn = r;
        din  = d;
        en   = e;
        exp_q.push_back(exp);
        id_q.push_back(id);
    endtask

    // din changes to 'to' before edge 1; dout follows on edge 19.
    task automatic edge_change(input logic to, input int id);
        for (int k = 1; k <= 22; k++) begin
            cyc(1'b1, to, 1'b1,
                {(k >= 19) ? to : ~to, (k == 19) && to, (k == 19) && !to, (k >= 3) && (k <= 18)},
                id);
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        int         id;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check(nm(id), {dout, rise, fall, busy}, e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        total  = 0;
        passed = 0;
        rstn   = 1'b0;
        din    = 1'b0;
        en     = 1'b1;
        #1;
        check("reset_initial", {dout, rise, fall, busy}, 4'b0000);

        for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 1'b1, 4'b0000, ID_PWR);

        // 10-cycle pulse: busy over edges 3..12, never accepted
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, k <= 10, 1'b1, {1'b0, 1'b0, 1'b0, (k >= 3) && (k <= 12)}, ID_GLT);
        end

        // en every 4th edge: 16th en edge in CHANGING is edge 64
        for (int k = 1; k <= 68; k++) begin
            cyc(1'b1, 1'b1, (k % 4) == 0,
                {k >= 64, k == 64, 1'b0, (k >= 3) && (k <= 63)}, ID_ENG);
        end

        edge_change(1'b0, ID_FALL);
        edge_change(1'b1, ID_RISE);

        // asynchronous reset with dout=1 and din=1 held
        @(negedge clk);
        rstn = 1'b0;
        din  = 1'b1;
        en   = 1'b1;
        #1;
        check("reset_async", {dout, rise, fall, busy}, 4'b0000);
        @(posedge clk);
        #2;
        check("reset_held", {dout, rise, fall, busy}, 4'b0000);
        for (int k = 1; k <= 40; k++) cyc(1'b1, 1'b0, 1'b1, 4'b0000, ID_QUIET);

        // start a rise, reset once cnt has reached 8 (after edge 11)
        for (int k = 1; k <= 11; k++) begin
            cyc(1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, k >= 3}, ID_MID);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("reset_midcount_async", {dout, rise, fall, busy}, 4'b0000);
        @(posedge clk);
        #2;
        check("reset_midcount_held", {dout, rise, fall, busy}, 4'b0000);
        edge_change(1'b1, ID_MID);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
